// File: rtl/mips_instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder.
// Holds the command-kind encodings, the opcode and funct constants (these must
// match the single-cycle control unit's decode), the NOP word, the FSM state
// type and the combinational command-to-word encoder.
package mips_instr_encoder_pkg;

    typedef enum logic [3:0] {
        KIND_ADD = 4'd0,
        KIND_SUB = 4'd1,
        KIND_AND = 4'd2,
        KIND_OR  = 4'd3,
        KIND_SLT = 4'd4,
        KIND_LW  = 4'd5,
        KIND_SW  = 4'd6,
        KIND_BEQ = 4'd7,
        KIND_ORI = 4'd8,
        KIND_LUI = 4'd9,
        KIND_J   = 4'd10,
        KIND_JAL = 4'd11
    } cmd_kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [31:0] NOP_WORD = '0;

    typedef enum logic {
        ST_IDLE,
        ST_PAD
    } enc_state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_result_t;

    function automatic enc_result_t encode_cmd(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        enc_result_t r;
        r.legal = 1'b1;
        r.word  = '0;
        case (kind)
            KIND_ADD: r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
            KIND_SUB: r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
            KIND_AND: r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
            KIND_OR:  r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
            KIND_SLT: r.word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
            KIND_LW:  r.word = {OP_LW,  rs, rt, imm};
            KIND_SW:  r.word = {OP_SW,  rs, rt, imm};
            KIND_BEQ: r.word = {OP_BEQ, rs, rt, imm};
            KIND_ORI: r.word = {OP_ORI, rs, rt, imm};
            KIND_LUI: r.word = {OP_LUI, 5'd0, rt, imm};   // rs is not part of LUI
            KIND_J:   r.word = {OP_J,   target};
            KIND_JAL: r.word = {OP_JAL, target};
            default:  r.legal = 1'b0;
        endcase
        return r;
    endfunction

    // Control-transfer kinds that get a delay-slot nop when padding is built in.
    function automatic logic is_pad_kind(input logic [3:0] kind);
        return (kind == KIND_BEQ) || (kind == KIND_J) || (kind == KIND_JAL);
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Command and output-stream bundle for mips_instr_encoder.
//   cmd_*  : symbolic command in, valid/ready handshake
//   out_*  : encoded word stream out with word address, valid/ready handshake
// Modports: master = command producer / word consumer, slave = the encoder.
interface mips_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_kind;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [15:0]       cmd_imm;
    logic [25:0]       cmd_target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target,
        output out_ready,
        input  cmd_ready, out_valid, out_word, out_addr
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target,
        input  out_ready,
        output cmd_ready, out_valid, out_word, out_addr
    );
endinterface

// File: rtl/mips_instr_encoder_instr_fifo.sv
// instr_fifo: DEPTH x WIDTH synchronous FIFO with first-word-visible head.
//   clock, reset      : clock and synchronous active-high reset
//   push_i/push_data_i: write (ignored when full)
//   pop_i             : read (ignored when empty)
//   full_o, empty_o   : occupancy flags
//   head_o            : current head entry (valid when !empty_o)
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o   = (count_q == CNT_W'(DEPTH));
        empty_o  = (count_q == '0);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        head_o   = mem_q[rd_ptr_q];
        // DEPTH is a power of two, so pointers wrap by plain overflow
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs symbolic commands into 32-bit MIPS words, buffers
// them in instr_fifo and streams them out with an incrementing word address.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : cmd_* handshake in, out_* word stream out
//   err          : sticky flag, set when an illegal cmd_kind is accepted
// Optional feature macro INSTR_ENC_NOP_PAD_EN: after a legal BEQ/J/JAL the
// encoder enters PAD, blocks commands, and pushes one nop word behind it.
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    mips_instr_encoder_if.slave  bus,
    output logic                 err
);
    enc_state_e        state_q, state_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    enc_result_t       enc;
    logic              cmd_ready_w, accept, push, pop, full, empty;
    logic [31:0]       push_word, head_word;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head_word)
    );

    always_comb begin
        enc = encode_cmd(bus.cmd_kind, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd,
                         bus.cmd_imm, bus.cmd_target);
        // Depends only on registered state: no path from out_ready
        cmd_ready_w = !full && (state_q == ST_IDLE);
        accept      = bus.cmd_valid && cmd_ready_w;
        pop         = !empty && bus.out_ready;
        state_d     = state_q;
        push        = accept && enc.legal;
        push_word   = enc.word;
        err_d       = err_q || (accept && !enc.legal);
        addr_d      = pop ? addr_q + ADDR_W'(1) : addr_q;
`ifdef INSTR_ENC_NOP_PAD_EN
        case (state_q)
            ST_IDLE: begin
                if (accept && enc.legal && is_pad_kind(bus.cmd_kind)) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                // Commands are blocked in PAD, so this push never collides
                if (!full) begin
                    push      = 1'b1;
                    push_word = NOP_WORD;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            addr_q  <= ADDR_W'(BASE_ADDR);
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_w;
    assign bus.out_valid = !empty;
    assign bus.out_word  = empty ? '0 : head_word;
    assign bus.out_addr  = addr_q;
    assign err           = err_q;
endmodule
